// File: rtl/lift_pkg.sv
// Shared encodings, FSM state type and default door timings for the lift call scheduler.
package lift_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int unsigned DefDwellCycles = 8;
    localparam int unsigned DefCloseCycles = 4;

    typedef enum logic [2:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StOpen,
        StClosing
    } lift_state_e;

    typedef enum logic [1:0] {
        SvcNone,
        SvcUp,
        SvcDown
    } svc_dir_e;

    function automatic logic [1:0] state_motor_dir(input lift_state_e st);
        logic [1:0] dir;
        case (st)
            StMoveUp:   dir = DIR_UP;
            StMoveDown: dir = DIR_DOWN;
            default:    dir = DIR_IDLE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Loadable down-counter shared by the door open-dwell and closing phases.
module lift_door_timer #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lift_call_scheduler.sv
// Single-car collective-selective scheduler: call latches, floor tracking, SCAN FSM
// and door sequencing, with all outputs registered.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = 4,
    parameter int unsigned FLOOR_W      = 2,
    parameter int unsigned DWELL_CYCLES = DefDwellCycles,
    parameter int unsigned CLOSE_CYCLES = DefCloseCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_FLOORS-1:0] hall_up_i,
    input  logic [NUM_FLOORS-1:0] hall_down_i,
    input  logic [NUM_FLOORS-1:0] car_call_i,
    input  logic [NUM_FLOORS-1:0] floor_sensor_i,
    input  logic                  door_obstruct_i,
    output logic [1:0]            motor_dir_o,
    output logic                  door_open_o,
    output logic [FLOOR_W-1:0]    cur_floor_o,
    output logic [NUM_FLOORS-1:0] up_pending_o,
    output logic [NUM_FLOORS-1:0] down_pending_o,
    output logic [NUM_FLOORS-1:0] car_pending_o,
    output logic                  sensor_err_o
);

    localparam int unsigned MaxLoad = (DWELL_CYCLES > CLOSE_CYCLES) ? DWELL_CYCLES : CLOSE_CYCLES;
    localparam int unsigned TimerW  = $clog2(MaxLoad) + 1;
    localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL_CYCLES - 1);
    localparam logic [TimerW-1:0] CloseLoad = TimerW'(CLOSE_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TopFloor = FLOOR_W'(NUM_FLOORS - 1);
    // Top floor has no up button and the bottom floor has no down button.
    localparam logic [NUM_FLOORS-1:0] UpMask   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DownMask = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    lift_state_e state_q, state_d;
    svc_dir_e    svc_q, svc_d;
    logic [1:0]  motor_q;
    logic        door_q;
    logic        err_q;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] up_q, up_d, down_q, down_d, car_q, car_d;
    logic [NUM_FLOORS-1:0] clr_up, clr_down, clr_car, blk_up, blk_down, blk_car;

    logic                  sensor_multi, sensor_valid, arrival;
    logic [FLOOR_W-1:0]    sensor_idx;
    logic [NUM_FLOORS-1:0] all_pend, cur_oh;
    logic                  calls_above, calls_below, arr_above, arr_below;
    logic                  stop_up, stop_down, new_here;
    logic                  tmr_load, tmr_done;
    logic [TimerW-1:0]     tmr_val;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    always_comb begin
        sensor_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_sensor_i[i]) sensor_idx = FLOOR_W'(i);
        end
    end

    assign sensor_multi = (floor_sensor_i & (floor_sensor_i - NUM_FLOORS'(1))) != '0;
    assign sensor_valid = (|floor_sensor_i) && !sensor_multi;
    assign arrival      = sensor_valid && (sensor_idx != floor_q);

    assign all_pend    = up_q | down_q | car_q;
    assign cur_oh      = NUM_FLOORS'(1) << floor_q;
    assign calls_above = |(all_pend & above_mask(floor_q));
    assign calls_below = |(all_pend & below_mask(floor_q));
    assign arr_above   = |(all_pend & above_mask(sensor_idx));
    assign arr_below   = |(all_pend & below_mask(sensor_idx));

    assign stop_up   = car_q[sensor_idx] || up_q[sensor_idx] || (sensor_idx == TopFloor) ||
                       (!arr_above && down_q[sensor_idx]);
    assign stop_down = car_q[sensor_idx] || down_q[sensor_idx] || (sensor_idx == '0) ||
                       (!arr_below && up_q[sensor_idx]);

    // Calls at the open floor that the current service direction would take right now.
    assign new_here = |((car_call_i & blk_car) | (hall_up_i & UpMask & blk_up) |
                        (hall_down_i & DownMask & blk_down));

    always_comb begin
        state_d  = state_q;
        svc_d    = svc_q;
        clr_up   = '0;
        clr_down = '0;
        clr_car  = '0;
        blk_up   = '0;
        blk_down = '0;
        blk_car  = '0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (|(all_pend & cur_oh)) begin
                    state_d  = StOpen;
                    svc_d    = SvcNone;
                    clr_up   = cur_oh;
                    clr_down = cur_oh;
                    clr_car  = cur_oh;
                    tmr_load = 1'b1;
                    tmr_val  = DwellLoad;
                end else if (calls_above) begin
                    state_d = StMoveUp;
                end else if (calls_below) begin
                    state_d = StMoveDown;
                end
            end
            StMoveUp: begin
                if (arrival && stop_up) begin
                    state_d  = StOpen;
                    svc_d    = SvcUp;
                    clr_car  = floor_sensor_i;
                    clr_up   = floor_sensor_i;
                    clr_down = arr_above ? '0 : floor_sensor_i;
                    tmr_load = 1'b1;
                    tmr_val  = DwellLoad;
                end
            end
            StMoveDown: begin
                if (arrival && stop_down) begin
                    state_d  = StOpen;
                    svc_d    = SvcDown;
                    clr_car  = floor_sensor_i;
                    clr_down = floor_sensor_i;
                    clr_up   = arr_below ? '0 : floor_sensor_i;
                    tmr_load = 1'b1;
                    tmr_val  = DwellLoad;
                end
            end
            StOpen: begin
                blk_car  = cur_oh;
                blk_up   = (svc_q != SvcDown) ? cur_oh : '0;
                blk_down = (svc_q != SvcUp) ? cur_oh : '0;
                if (door_obstruct_i || new_here) begin
                    tmr_load = 1'b1;
                    tmr_val  = DwellLoad;
                end else if (tmr_done) begin
                    state_d  = StClosing;
                    tmr_load = 1'b1;
                    tmr_val  = CloseLoad;
                end
            end
            StClosing: begin
                if (door_obstruct_i) begin
                    state_d  = StOpen;
                    tmr_load = 1'b1;
                    tmr_val  = DwellLoad;
                end else if (tmr_done) begin
                    if (svc_q == SvcUp) begin
                        state_d = calls_above ? StMoveUp : (calls_below ? StMoveDown : StIdle);
                    end else if (svc_q == SvcDown) begin
                        state_d = calls_below ? StMoveDown : (calls_above ? StMoveUp : StIdle);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign floor_d = sensor_valid ? sensor_idx : floor_q;
    // Clears are applied last so a served floor drops a coincident press.
    assign up_d    = (up_q | (hall_up_i & UpMask & ~blk_up)) & ~clr_up;
    assign down_d  = (down_q | (hall_down_i & DownMask & ~blk_down)) & ~clr_down;
    assign car_d   = (car_q | (car_call_i & ~blk_car)) & ~clr_car;

    lift_door_timer #(
        .CntW(TimerW)
    ) u_door_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            svc_q   <= SvcNone;
            motor_q <= DIR_IDLE;
            door_q  <= 1'b0;
            err_q   <= 1'b0;
            floor_q <= '0;
            up_q    <= '0;
            down_q  <= '0;
            car_q   <= '0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            motor_q <= state_motor_dir(state_d);
            door_q  <= (state_d == StOpen) || (state_d == StClosing);
            err_q   <= err_q | sensor_multi;
            floor_q <= floor_d;
            up_q    <= up_d;
            down_q  <= down_d;
            car_q   <= car_d;
        end
    end

    assign motor_dir_o    = motor_q;
    assign door_open_o    = door_q;
    assign cur_floor_o    = floor_q;
    assign up_pending_o   = up_q;
    assign down_pending_o = down_q;
    assign car_pending_o  = car_q;
    assign sensor_err_o   = err_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with hand-computed expectations.
module tb_lift_call_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] hall_up, hall_down, car_call, floor_sensor;
    logic       door_obstruct;
    logic [1:0] motor_dir;
    logic       door_open;
    logic [1:0] cur_floor;
    logic [3:0] up_pending, down_pending, car_pending;
    logic       sensor_err;

    int checks = 0;
    int errors = 0;

    lift_call_scheduler dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .hall_up_i      (hall_up),
        .hall_down_i    (hall_down),
        .car_call_i     (car_call),
        .floor_sensor_i (floor_sensor),
        .door_obstruct_i(door_obstruct),
        .motor_dir_o    (motor_dir),
        .door_open_o    (door_open),
        .cur_floor_o    (cur_floor),
        .up_pending_o   (up_pending),
        .down_pending_o (down_pending),
        .car_pending_o  (car_pending),
        .sensor_err_o   (sensor_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic walk(input int from, input int to);
        int f;
        f = from;
        while (f != to) begin
            f = (to > from) ? f + 1 : f - 1;
            floor_sensor = 4'b0000;
            tick();
            floor_sensor = 4'(1 << f);
            tick();
        end
    endtask

    initial begin
        hall_up = '0; hall_down = '0; car_call = '0;
        floor_sensor = 4'b0001; door_obstruct = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_motor", motor_dir, 2'b00);
        chk("rst_door", door_open, 1'b0);
        chk("rst_floor", cur_floor, 2'd0);
        chk("rst_pend", {up_pending, down_pending, car_pending}, 12'h000);
        chk("rst_err", sensor_err, 1'b0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();

        // Idle up-call from floor 0 to floor 2, passing floor 1.
        hall_up = 4'b0100;
        tick();
        chk("upcall_latched", up_pending, 4'b0100);
        chk("upcall_still_idle", motor_dir, 2'b00);
        hall_up = 4'b0000;
        tick();
        chk("upcall_move_up", motor_dir, 2'b01);
        walk(0, 1);
        chk("pass_f1_floor", cur_floor, 2'd1);
        chk("pass_f1_motor", motor_dir, 2'b01);
        chk("pass_f1_pend", up_pending, 4'b0100);
        walk(1, 2);
        chk("arrive_f2_motor", motor_dir, 2'b00);
        chk("arrive_f2_door", door_open, 1'b1);
        chk("arrive_f2_clear", up_pending, 4'b0000);
        chk("arrive_f2_floor", cur_floor, 2'd2);
        step(11);
        chk("door_12th_cycle", door_open, 1'b1);
        step(1);
        chk("door_closed", door_open, 1'b0);
        chk("back_idle_motor", motor_dir, 2'b00);

        // Multi-hot sensor: sticky error, floor held, FSM unaffected.
        floor_sensor = 4'b0110;
        tick();
        chk("sens_err_set", sensor_err, 1'b1);
        chk("sens_floor_held", cur_floor, 2'd2);
        chk("sens_motor_idle", motor_dir, 2'b00);
        chk("sens_door_shut", door_open, 1'b0);
        floor_sensor = 4'b0100;
        tick();
        chk("sens_err_sticky", sensor_err, 1'b1);

        // Car call at current floor, then obstruction in OPEN and CLOSING.
        car_call = 4'b0100;
        tick();
        chk("carcall_latched", car_pending, 4'b0100);
        car_call = 4'b0000;
        tick();
        chk("carcall_open", door_open, 1'b1);
        chk("carcall_cleared", car_pending, 4'b0000);
        door_obstruct = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("obs_door", door_open, 1'b1);
            chk("obs_motor", motor_dir, 2'b00);
        end
        door_obstruct = 1'b0;
        step(9);
        chk("closing_door", door_open, 1'b1);
        door_obstruct = 1'b1;
        tick();
        door_obstruct = 1'b0;
        step(11);
        chk("reopen_full_dwell", door_open, 1'b1);
        step(1);
        chk("reopen_then_idle", door_open, 1'b0);

        // Back down to floor 0.
        car_call = 4'b0001;
        tick();
        car_call = 4'b0000;
        tick();
        chk("down_move", motor_dir, 2'b10);
        walk(2, 1);
        chk("down_pass_f1", motor_dir, 2'b10);
        walk(1, 0);
        chk("down_arrive_f0", door_open, 1'b1);
        chk("down_arrive_floor", cur_floor, 2'd0);
        step(12);
        chk("down_idle", {motor_dir, door_open}, 3'b000);

        // Collective order: pass floor 2 up, serve 3, reverse, serve down call at 2.
        car_call = 4'b1000;
        hall_down = 4'b0100;
        tick();
        chk("coll_car_latched", car_pending, 4'b1000);
        chk("coll_down_latched", down_pending, 4'b0100);
        car_call = 4'b0000;
        hall_down = 4'b0000;
        tick();
        chk("coll_move_up", motor_dir, 2'b01);
        walk(0, 2);
        chk("coll_pass_f2_motor", motor_dir, 2'b01);
        chk("coll_pass_f2_pend", down_pending, 4'b0100);
        walk(2, 3);
        chk("coll_stop_f3", {motor_dir, door_open}, 3'b001);
        chk("coll_f3_clear", car_pending, 4'b0000);
        step(11);
        chk("coll_f3_door", door_open, 1'b1);
        step(1);
        chk("coll_reverse", motor_dir, 2'b10);
        walk(3, 2);
        chk("coll_stop_f2", {motor_dir, door_open}, 3'b001);
        chk("coll_f2_clear", down_pending, 4'b0000);
        step(12);
        chk("coll_idle", {motor_dir, door_open}, 3'b000);

        // Return to floor 0, then reset in the middle of an up run.
        car_call = 4'b0001;
        tick();
        car_call = 4'b0000;
        tick();
        walk(2, 0);
        step(12);
        chk("ret_floor0", cur_floor, 2'd0);
        chk("err_before_rst", sensor_err, 1'b1);
        hall_up = 4'b0100;
        tick();
        hall_up = 4'b0000;
        tick();
        chk("mid_move_up", motor_dir, 2'b01);
        chk("mid_up_pend", up_pending, 4'b0100);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_motor", motor_dir, 2'b00);
        chk("mid_rst_door", door_open, 1'b0);
        chk("mid_rst_pend", {up_pending, down_pending, car_pending}, 12'h000);
        chk("mid_rst_floor", cur_floor, 2'd0);
        chk("mid_rst_err", sensor_err, 1'b0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();

        // Going up with only a down call at floor 2: stop there and clear it.
        hall_down = 4'b0100;
        tick();
        hall_down = 4'b0000;
        tick();
        chk("rev_move_up", motor_dir, 2'b01);
        walk(0, 1);
        chk("rev_pass_f1", down_pending, 4'b0100);
        walk(1, 2);
        chk("rev_stop", {motor_dir, door_open}, 3'b001);
        chk("rev_clear", down_pending, 4'b0000);
        step(12);
        chk("rev_idle", {motor_dir, door_open}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Single-car collective-selective scheduler for the lift datapath.
- Latches hall calls (up/down per floor) and car calls, and tracks car position from the one-hot floor sensor.
- Drives motor direction and runs the door open/dwell/close sequence; serves calls in SCAN order.
- Sits between the floor call buttons and sensors and the motor/door drivers.

Parameters:
- NUM_FLOORS, 4, number of floors; floor 0 is the bottom.
- FLOOR_W, 2, width of the floor index; equals clog2(NUM_FLOORS).
- DWELL_CYCLES, 8, clock cycles the door stays fully open.
- CLOSE_CYCLES, 4, clock cycles spent closing the door.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hall_up  in  NUM_FLOORS  level up-call buttons, bit f = floor f.
- hall_down  in  NUM_FLOORS  level down-call buttons.
- car_call  in  NUM_FLOORS  level in-car floor buttons.
- floor_sensor  in  NUM_FLOORS  one-hot car-at-floor; all zero = between floors.
- door_obstruct  in  1  door beam broken.
- motor_dir  out  2  00 idle, 01 up, 10 down; 11 never driven.
- door_open  out  1  door commanded open; high in OPEN and CLOSING.
- cur_floor  out  FLOOR_W  last valid floor index.
- up_pending  out  NUM_FLOORS  latched hall-up calls (lamps).
- down_pending  out  NUM_FLOORS  latched hall-down calls.
- car_pending  out  NUM_FLOORS  latched car calls.
- sensor_err  out  1  sticky flag: more than one floor_sensor bit seen.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, motor_dir 00, door_open 0, cur_floor 0, all pending 0, sensor_err 0, timers 0.
- All outputs are registered.
- Call latching: pending[f] <= pending[f] | input[f] each cycle, except when the call is being served (see OPEN).
- A call sampled at edge k shows on its pending output after edge k.
- Floor tracking: a valid one-hot sensor updates cur_floor. All-zero holds cur_floor.
- Multi-hot sensor: hold cur_floor, set sensor_err, and ignore that sample.
- Arrival event: valid sensor with index != cur_floor.
- Top floor has no hall_up and floor 0 has no hall_down; those input bits are ignored and never latch.
- "above"/"below" = any pending bit (any kind) strictly above/below cur_floor.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, OPEN, CLOSING. Moore outputs.
  - motor_dir is 01 only in MOVE_UP and 10 only in MOVE_DOWN.
  - door_open=1 only in OPEN and CLOSING. Motor and door are never both active.
- IDLE, first match wins:
  - any pending at cur_floor -> OPEN, clear all three pending bits at cur_floor;
  - else above -> MOVE_UP;
  - else below -> MOVE_DOWN;
  - else stay IDLE.
  - Up wins when calls exist both above and below.
- MOVE_UP, on arrival at f: stop if car[f], up[f], f = NUM_FLOORS-1, or (no calls above f and down[f]). Otherwise continue.
  - On stop: go to OPEN and clear car[f] and up[f].
  - Also clear down[f] only if no calls remain above f.
  - Remember travel direction (svc_dir).
- MOVE_DOWN: mirror of MOVE_UP (floor 0 always stops).
- OPEN: load dwell timer with DWELL_CYCLES-1 on entry and count to 0.
  - Reload the timer while door_obstruct=1.
  - Reload the timer on a new call at cur_floor that would be served now (car, or hall in svc_dir, or either hall if svc_dir none). That call is not latched.
  - At 0 with door_obstruct=0 -> CLOSING.
- CLOSING: count CLOSE_CYCLES.
  - door_obstruct=1 -> back to OPEN (timer reloaded).
  - Done -> continue svc_dir if calls lie beyond; else reverse if calls lie behind; else IDLE.
- Arrival while in OPEN, CLOSING or IDLE (sensor glitch): update cur_floor only, no state change.
- Simultaneous events: in the same cycle, clear takes priority over set for a served floor.

Decomposition:
- Package lift_pkg holds:
  - motor_dir encodings DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10;
  - the FSM state enum;
  - default DWELL_CYCLES and CLOSE_CYCLES.
- Sub-module lift_door_timer: loadable down-counter with reload and done outputs, instanced once and shared by OPEN and CLOSING.
- Scheduler FSM, call latches and floor tracker stay in the top module.

Test Plan:
- Reset mid-operation: assert rst low during MOVE_UP with up_pending=0100 -> same cycle motor_dir=00, door_open=0, all pending 0, cur_floor 0.
- Idle up-call: cur_floor 0, pulse hall_up=0100 -> up_pending=0100 next cycle, motor_dir=01 one cycle later. floor_sensor 0010 passes without stopping. At 0100 -> motor_dir 00, door_open=1 for DWELL+CLOSE=12 cycles, up_pending=0000, then IDLE.
- Collective order: car at 0, car_call=1000 and hall_down=0100 latched -> passes floor 2 going up and stops at 3. Then reverses, stops at 2, and clears down_pending[2] there.
- Reversal clear: car moving up, only hall_down[2] pending -> stops at 2 and clears down_pending=0000.
- Obstruction: hold door_obstruct=1 for 20 cycles in OPEN -> door_open stays 1 and motor_dir 00 throughout. Obstruction during CLOSING -> returns to OPEN with the full dwell reloaded.
- Sensor fault: floor_sensor=0110 -> sensor_err=1 (sticky), cur_floor unchanged, FSM unaffected. Cleared only by rst.
